de_reg: RTL and testbench
=========================

DE_REG -- requirements
Module: de_reg

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-003 SHALL have port: stall  input  1  D stage held by hazard unit; inject bubble into E.
REQ-004 SHALL have port: flush  input  1  kill the instruction entering E.
REQ-005 SHALL have port: hold  input  1  freeze E contents (downstream busy).
REQ-006 SHALL have ports: D_PC, D_Instr, D_RD1, D_RD2, D_Ext32  input  32 each  decode-stage PC, instruction, GRF read data, extender output.
REQ-007 SHALL have ports: D_A3  input  5  destination register; D_Tnew  input  2  cycles until result ready, counted from D.
REQ-008 SHALL have ports: E_PC, E_Instr, E_RD1, E_RD2, E_Ext32  output  32; E_A3  output  5; E_Tnew  output  2; E_valid  output  1.
REQ-009 SHALL have port: bubble_cnt  output  32  count of stall-inserted bubbles.

Function
REQ-010 All outputs SHALL be registered; no combinational input-to-output path.
REQ-011 Per-edge priority SHALL be flush > hold > stall > load.
REQ-012 Load: E_PC, E_Instr, E_RD1, E_RD2, E_Ext32, E_A3 SHALL take the D_* values; E_valid SHALL become 1; one-cycle latency.
REQ-013 On load, E_Tnew SHALL be D_Tnew-1, saturating at 0 (D_Tnew=0 -> 0).
REQ-014 Bubble (stall or flush): E_Instr, E_RD1, E_RD2, E_Ext32 SHALL be 0; E_A3 = 0; E_Tnew = 0; E_valid = 0; E_PC SHALL take D_PC.
REQ-015 Hold: every output SHALL retain its value, including E_valid and E_Tnew.
REQ-016 hold with stall asserted SHALL hold; the stall bubble is not inserted and SHALL NOT be counted.
REQ-017 flush with hold asserted SHALL bubble (flush wins).
REQ-018 bubble_cnt SHALL increment by 1 on each edge where stall=1, flush=0 and hold=0.
REQ-019 bubble_cnt SHALL saturate at 32'hFFFF_FFFF, with no wrap.
REQ-020 Flush-caused bubbles SHALL NOT increment bubble_cnt.
REQ-021 E_A3=0 SHALL denote "no write"; the block SHALL NOT otherwise alter A3.

Reset
REQ-022 While reset=0, all outputs SHALL be 0 immediately, independent of clk: E_PC = 0, E_Instr = 0 (NOP), E_valid = 0, bubble_cnt = 0.
REQ-023 Reset asserted mid-hold or mid-stall SHALL discard held contents; after release, the first edge SHALL follow REQ-011 normally.

Structure
REQ-024 Shared package SHALL hold NOP_INSTR = 32'h0000_0000, TNEW_W = 2, and REG_ADDR_W = 5.
REQ-025 The block SHALL be a single module with no sub-module.
REQ-026 The saturating Tnew decrement and the bubble counter SHALL be written inline.

Verification
REQ-027 Scenario, load: D_PC=0x3004, D_Instr=0x3421_FFFF, D_Ext32=0x0000_FFFF, D_Tnew=2, D_A3=1. Next edge -> E_* equal inputs, E_Tnew=1, E_valid=1.
REQ-028 Scenario, stall: stall=1 for 3 edges with D_PC=0x3008. Each edge -> E_Instr=0, E_valid=0, E_PC=0x3008; bubble_cnt 0->3.
REQ-029 Scenario, hold over stall: E loaded with Instr 0x0000_0018; then hold=1 and stall=1 for 2 edges -> E_Instr stays 0x0000_0018; bubble_cnt unchanged.
REQ-030 Scenario, flush over hold: flush=1 and hold=1 together -> E_Instr=0, E_valid=0; bubble_cnt unchanged.
REQ-031 Scenario, saturation: bubble_cnt forced to 0xFFFF_FFFE, then 3 stall edges -> bubble_cnt=0xFFFF_FFFF. Separately, D_Tnew=0 load -> E_Tnew=0.
REQ-032 Scenario, async reset: reset=0 pulsed between edges while E_valid=1 -> all outputs 0 before the next edge.

Source files
------------

// File: rtl/de_reg_pkg.sv
// Shared constants and types for the decode/execute pipeline register.
package de_reg_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam int          TNEW_W     = 2;
    localparam int          REG_ADDR_W = 5;

    // What the E register does on a given edge
    typedef enum logic [1:0] {
        ACT_LOAD   = 2'd0,
        ACT_STALL  = 2'd1,
        ACT_HOLD   = 2'd2,
        ACT_FLUSH  = 2'd3
    } de_act_t;

    // Resolve control inputs: flush beats hold, hold beats stall, stall beats load
    function automatic de_act_t de_decode(input logic flush, input logic hold, input logic stall);
        if (flush)
            return ACT_FLUSH;
        else if (hold)
            return ACT_HOLD;
        else if (stall)
            return ACT_STALL;
        else
            return ACT_LOAD;
    endfunction

endpackage

// File: rtl/de_reg.sv
// D->E pipeline register: loads decode results, inserts bubbles on stall or
// flush, freezes under hold, and counts stall-inserted bubbles.
module de_reg
    import de_reg_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  hold,
    input  logic [31:0]           D_PC,
    input  logic [31:0]           D_Instr,
    input  logic [31:0]           D_RD1,
    input  logic [31:0]           D_RD2,
    input  logic [31:0]           D_Ext32,
    input  logic [REG_ADDR_W-1:0] D_A3,
    input  logic [TNEW_W-1:0]     D_Tnew,
    output logic [31:0]           E_PC,
    output logic [31:0]           E_Instr,
    output logic [31:0]           E_RD1,
    output logic [31:0]           E_RD2,
    output logic [31:0]           E_Ext32,
    output logic [REG_ADDR_W-1:0] E_A3,
    output logic [TNEW_W-1:0]     E_Tnew,
    output logic                  E_valid,
    output logic [31:0]           bubble_cnt
);

    de_act_t act;

    // Per-edge action after priority resolution
    always_comb begin
        act = de_decode(flush, hold, stall);
    end

    // E-stage contents; bubbles keep D_PC so the PC stays traceable through E
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            E_PC    <= '0;
            E_Instr <= NOP_INSTR;
            E_RD1   <= '0;
            E_RD2   <= '0;
            E_Ext32 <= '0;
            E_A3    <= '0;
            E_Tnew  <= '0;
            E_valid <= 1'b0;
        end else begin
            case (act)
                ACT_LOAD: begin
                    E_PC    <= D_PC;
                    E_Instr <= D_Instr;
                    E_RD1   <= D_RD1;
                    E_RD2   <= D_RD2;
                    E_Ext32 <= D_Ext32;
                    E_A3    <= D_A3;
                    // One stage closer to the result, floored at zero
                    E_Tnew  <= (D_Tnew == '0) ? '0 : D_Tnew - 1'b1;
                    E_valid <= 1'b1;
                end
                ACT_STALL, ACT_FLUSH: begin
                    E_PC    <= D_PC;
                    E_Instr <= NOP_INSTR;
                    E_RD1   <= '0;
                    E_RD2   <= '0;
                    E_Ext32 <= '0;
                    E_A3    <= '0;
                    E_Tnew  <= '0;
                    E_valid <= 1'b0;
                end
                default: begin
                    // ACT_HOLD: every field keeps its value
                end
            endcase
        end
    end

    // Saturating count of stall bubbles; flush bubbles and held stalls are not counted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            bubble_cnt <= '0;
        else if (act == ACT_STALL && bubble_cnt != 32'hFFFF_FFFF)
            bubble_cnt <= bubble_cnt + 32'd1;
    end

endmodule

// File: tb/tb_de_reg.sv
// Directed self-checking bench for de_reg.
module tb_de_reg;
    import de_reg_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, flush, hold;
    logic [31:0] D_PC, D_Instr, D_RD1, D_RD2, D_Ext32;
    logic [4:0]  D_A3;
    logic [1:0]  D_Tnew;
    logic [31:0] E_PC, E_Instr, E_RD1, E_RD2, E_Ext32;
    logic [4:0]  E_A3;
    logic [1:0]  E_Tnew;
    logic        E_valid;
    logic [31:0] bubble_cnt;

    int checks   = 0;
    int failures = 0;

    de_reg dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .hold(hold),
        .D_PC(D_PC), .D_Instr(D_Instr), .D_RD1(D_RD1), .D_RD2(D_RD2),
        .D_Ext32(D_Ext32), .D_A3(D_A3), .D_Tnew(D_Tnew),
        .E_PC(E_PC), .E_Instr(E_Instr), .E_RD1(E_RD1), .E_RD2(E_RD2),
        .E_Ext32(E_Ext32), .E_A3(E_A3), .E_Tnew(E_Tnew), .E_valid(E_valid),
        .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] instr,
                         input logic [31:0] rd1, input logic [31:0] rd2,
                         input logic [31:0] ext, input logic [4:0] a3,
                         input logic [1:0] tnew);
        D_PC = pc; D_Instr = instr; D_RD1 = rd1; D_RD2 = rd2;
        D_Ext32 = ext; D_A3 = a3; D_Tnew = tnew;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full bubble signature in E
    task automatic chk_bubble(input string tag, input logic [31:0] pc);
        chk({tag, "_pc"},    E_PC, pc);
        chk({tag, "_instr"}, E_Instr, 32'h0);
        chk({tag, "_rd1"},   E_RD1, 32'h0);
        chk({tag, "_rd2"},   E_RD2, 32'h0);
        chk({tag, "_ext"},   E_Ext32, 32'h0);
        chk({tag, "_a3"},    {27'h0, E_A3}, 32'h0);
        chk({tag, "_tnew"},  {30'h0, E_Tnew}, 32'h0);
        chk({tag, "_valid"}, {31'h0, E_valid}, 32'h0);
    endtask

    initial begin
        // Reset held with busy inputs: outputs must stay zero across edges
        reset = 1'b0; stall = 1'b0; flush = 1'b0; hold = 1'b0;
        drive(32'h1111_1111, 32'h2222_2222, 32'h3, 32'h4, 32'h5, 5'd7, 2'd3);
        tick(); tick();
        chk_bubble("rst", 32'h0);
        chk("rst_cnt", bubble_cnt, 32'h0);

        // Load
        reset = 1'b1;
        drive(32'h0000_3004, 32'h3421_FFFF, 32'hAAAA_0001, 32'hBBBB_0002, 32'h0000_FFFF, 5'd1, 2'd2);
        tick();
        chk("ld_pc",    E_PC, 32'h0000_3004);
        chk("ld_instr", E_Instr, 32'h3421_FFFF);
        chk("ld_rd1",   E_RD1, 32'hAAAA_0001);
        chk("ld_rd2",   E_RD2, 32'hBBBB_0002);
        chk("ld_ext",   E_Ext32, 32'h0000_FFFF);
        chk("ld_a3",    {27'h0, E_A3}, 32'd1);
        chk("ld_tnew",  {30'h0, E_Tnew}, 32'd1);
        chk("ld_valid", {31'h0, E_valid}, 32'd1);
        chk("ld_cnt",   bubble_cnt, 32'd0);

        // Three stall edges
        stall = 1'b1;
        drive(32'h0000_3008, 32'hDEAD_BEEF, 32'h9, 32'h9, 32'h9, 5'd9, 2'd2);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk_bubble("stall", 32'h0000_3008);
            chk("stall_cnt", bubble_cnt, i);
        end
        stall = 1'b0;

        // Load 0x18, then hold over stall for two edges
        drive(32'h0000_300C, 32'h0000_0018, 32'h1, 32'h2, 32'h3, 5'd5, 2'd1);
        tick();
        chk("ld18_instr", E_Instr, 32'h0000_0018);
        chk("ld18_tnew",  {30'h0, E_Tnew}, 32'd0);
        hold = 1'b1; stall = 1'b1;
        drive(32'h0000_3010, 32'hCAFE_0000, 32'h7, 32'h7, 32'h7, 5'd6, 2'd3);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("hs_instr", E_Instr, 32'h0000_0018);
            chk("hs_pc",    E_PC, 32'h0000_300C);
            chk("hs_a3",    {27'h0, E_A3}, 32'd5);
            chk("hs_valid", {31'h0, E_valid}, 32'd1);
            chk("hs_cnt",   bubble_cnt, 32'd3);
        end
        hold = 1'b0; stall = 1'b0;

        // Hold retains a nonzero Tnew
        drive(32'h0000_3014, 32'h0000_0020, 32'h1, 32'h2, 32'h3, 5'd8, 2'd3);
        tick();
        chk("t3_tnew", {30'h0, E_Tnew}, 32'd2);
        hold = 1'b1;
        drive(32'h0000_3018, 32'h0000_0024, 32'h0, 32'h0, 32'h0, 5'd0, 2'd0);
        tick();
        chk("hold_tnew",  {30'h0, E_Tnew}, 32'd2);
        chk("hold_instr", E_Instr, 32'h0000_0020);

        // Flush over hold
        flush = 1'b1;
        drive(32'h0000_301C, 32'h1234_5678, 32'h5, 32'h6, 32'h7, 5'd3, 2'd2);
        tick();
        chk_bubble("fh", 32'h0000_301C);
        chk("fh_cnt", bubble_cnt, 32'd3);
        hold = 1'b0;

        // Flush over stall is still not counted
        stall = 1'b1;
        tick();
        chk_bubble("fs", 32'h0000_301C);
        chk("fs_cnt", bubble_cnt, 32'd3);
        flush = 1'b0; stall = 1'b0;

        // Tnew floor at zero
        drive(32'h0000_3020, 32'h0000_0028, 32'h1, 32'h1, 32'h1, 5'd2, 2'd0);
        tick();
        chk("t0_tnew",  {30'h0, E_Tnew}, 32'd0);
        chk("t0_valid", {31'h0, E_valid}, 32'd1);
        chk("t0_a3",    {27'h0, E_A3}, 32'd2);

        // Counter saturation
        force dut.bubble_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.bubble_cnt;
        #1;
        chk("sat_pre", bubble_cnt, 32'hFFFF_FFFE);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sat_cnt", bubble_cnt, 32'hFFFF_FFFF);
        end
        stall = 1'b0;

        // Async reset between edges with valid contents, hold asserted
        drive(32'h0000_3030, 32'h0000_0030, 32'h4, 32'h5, 32'h6, 5'd4, 2'd2);
        tick();
        chk("ar_pre_valid", {31'h0, E_valid}, 32'd1);
        hold = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk_bubble("ar", 32'h0);
        chk("ar_cnt", bubble_cnt, 32'h0);
        #1;
        reset = 1'b1;

        // First edge after release: hold freezes the reset contents
        tick();
        chk("ar_hold_valid", {31'h0, E_valid}, 32'd0);
        chk("ar_hold_instr", E_Instr, 32'h0);
        hold = 1'b0;
        tick();
        chk("ar_ld_pc",    E_PC, 32'h0000_3030);
        chk("ar_ld_valid", {31'h0, E_valid}, 32'd1);
        chk("ar_ld_tnew",  {30'h0, E_Tnew}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
